// File: rtl/sram_axi_bridge_pkg.sv
// Shared types for sram_axi_bridge: read/write FSM encodings, AXI ids, size helper.
// Optional build macro used by the top: SRAM_AXI_RR_ARB_EN (round-robin read arbitration).
package sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_SEND = 2'd1,
    WR_B    = 2'd2
  } wr_state_e;

  localparam int unsigned ID_INST = 0;
  localparam int unsigned ID_DATA = 1;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  // sram-like size is log2(bytes) on 2 bits; AXI carries it on 3 bits
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_wr.sv
// Write channel of sram_axi_bridge: accepts data-port writes and sequences AW/W/B.
// AW and W complete independently; the B phase starts once both are done.
module sram_axi_bridge_wr
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        rd_busy_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic        idle_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  wr_state_e   state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;

  // next-state, capture and handshake decode
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    addr_ok_o = 1'b0;
    data_ok_o = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (req_i && !rd_busy_i && !reset_i) begin
          addr_ok_o = 1'b1;
          awaddr_d  = addr_i;
          awsize_d  = axi_size(size_i);
          wdata_d   = wdata_i;
          wstrb_d   = wstrb_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_SEND;
        end else begin
          state_d = WR_IDLE;
        end
      end
      WR_SEND: begin
        awvalid_d = awvalid_q & ~awready_i;
        wvalid_d  = wvalid_q & ~wready_i;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_B;
        end else begin
          state_d = WR_SEND;
        end
      end
      WR_B: begin
        if (bvalid_i) begin
          data_ok_o = !reset_i;
          state_d   = WR_IDLE;
        end else begin
          state_d = WR_B;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // state and AW/W payload registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= WR_IDLE;
      awaddr_q  <= 32'h0000_0000;
      awsize_q  <= 3'd0;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end

  assign idle_o    = (state_q == WR_IDLE);
  assign awaddr_o  = awaddr_q;
  assign awsize_o  = awsize_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = (state_q == WR_B);

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst (read-only) and data sram-like ports onto one AXI3 master.
// Build macro SRAM_AXI_RR_ARB_EN selects round-robin read arbitration instead of data-first.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_sram_req,
  input  logic [1:0]      inst_sram_size,
  input  logic [31:0]     inst_sram_addr,
  output logic            inst_sram_addr_ok,
  output logic            inst_sram_data_ok,
  output logic [31:0]     inst_sram_rdata,
  input  logic            data_sram_req,
  input  logic            data_sram_wr,
  input  logic [1:0]      data_sram_size,
  input  logic [3:0]      data_sram_wstrb,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic            data_sram_addr_ok,
  output logic            data_sram_data_ok,
  output logic [31:0]     data_sram_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [2:0]      arsize,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic            rvalid,
  output logic            rready,
  output logic [31:0]     awaddr,
  output logic [2:0]      awsize,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic            bvalid,
  output logic            bready
);

  rd_state_e       rd_q, rd_d;
  logic [ID_W-1:0] arid_q, arid_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [2:0]      arsize_q, arsize_d;
  logic            rd_data_q, rd_data_d;
`ifdef SRAM_AXI_RR_ARB_EN
  logic            last_grant_q, last_grant_d;
`endif

  logic wr_idle_s, wr_addr_ok_s, wr_data_ok_s;
  logic data_rd_req_s, grant_inst_s, grant_data_s;
  logic rd_data_busy_s, r_fire_s;

  // a data read must not overtake an outstanding write
  assign data_rd_req_s  = data_sram_req & ~data_sram_wr & wr_idle_s;
  assign rd_data_busy_s = rd_data_q & (rd_q != RD_IDLE);

  // read-channel arbitration, only while the read FSM is idle
  always_comb begin
    grant_inst_s = 1'b0;
    grant_data_s = 1'b0;
    if ((rd_q == RD_IDLE) && !reset) begin
`ifdef SRAM_AXI_RR_ARB_EN
      if (data_rd_req_s && inst_sram_req) begin
        grant_inst_s = (last_grant_q == GRANT_DATA);
        grant_data_s = (last_grant_q == GRANT_INST);
      end else begin
        grant_inst_s = inst_sram_req;
        grant_data_s = data_rd_req_s;
      end
`else
      if (data_rd_req_s) begin
        grant_data_s = 1'b1;
      end else begin
        grant_inst_s = inst_sram_req;
      end
`endif
    end else begin
      grant_inst_s = 1'b0;
      grant_data_s = 1'b0;
    end
  end

  // read FSM next state and AR payload capture
  always_comb begin
    rd_d      = rd_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    rd_data_d = rd_data_q;
    case (rd_q)
      RD_IDLE: begin
        if (grant_data_s) begin
          rd_d      = RD_AR;
          arid_d    = ID_W'(ID_DATA);
          araddr_d  = data_sram_addr;
          arsize_d  = axi_size(data_sram_size);
          rd_data_d = 1'b1;
        end else if (grant_inst_s) begin
          rd_d      = RD_AR;
          arid_d    = ID_W'(ID_INST);
          araddr_d  = inst_sram_addr;
          arsize_d  = axi_size(inst_sram_size);
          rd_data_d = 1'b0;
        end else begin
          rd_d = RD_IDLE;
        end
      end
      RD_AR: begin
        if (arready) begin
          rd_d = RD_R;
        end else begin
          rd_d = RD_AR;
        end
      end
      RD_R: begin
        if (rvalid) begin
          rd_d = RD_IDLE;
        end else begin
          rd_d = RD_R;
        end
      end
      default: rd_d = RD_IDLE;
    endcase
  end

`ifdef SRAM_AXI_RR_ARB_EN
  // remember which port won last so a tie next time favours the other
  always_comb begin
    if (grant_data_s) begin
      last_grant_d = GRANT_DATA;
    end else if (grant_inst_s) begin
      last_grant_d = GRANT_INST;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // arbitration history register
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GRANT_INST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // read FSM state and AR payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q      <= RD_IDLE;
      arid_q    <= '0;
      araddr_q  <= 32'h0000_0000;
      arsize_q  <= 3'd0;
      rd_data_q <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      rd_data_q <= rd_data_d;
    end
  end

  sram_axi_bridge_wr u_wr (
    .clk_i     (clk),
    .reset_i   (reset),
    .req_i     (data_sram_req & data_sram_wr),
    .rd_busy_i (rd_data_busy_s),
    .size_i    (data_sram_size),
    .addr_i    (data_sram_addr),
    .wdata_i   (data_sram_wdata),
    .wstrb_i   (data_sram_wstrb),
    .addr_ok_o (wr_addr_ok_s),
    .data_ok_o (wr_data_ok_s),
    .idle_o    (wr_idle_s),
    .awaddr_o  (awaddr),
    .awsize_o  (awsize),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .bready_o  (bready)
  );

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = (rd_q == RD_AR);
  assign rready  = (rd_q == RD_R);

  // the R beat is steered by rid; at most one data-port transfer is ever outstanding
  assign r_fire_s          = (rd_q == RD_R) & rvalid & ~reset;
  assign inst_sram_addr_ok = grant_inst_s;
  assign data_sram_addr_ok = grant_data_s | wr_addr_ok_s;
  assign inst_sram_data_ok = r_fire_s & (rid == ID_W'(ID_INST));
  assign data_sram_data_ok = (r_fire_s & (rid == ID_W'(ID_DATA))) | wr_data_ok_s;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: expected responses are queued at request
// acceptance and retired when the matching data_ok appears.
module tb_sram_axi_bridge;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]      inst_sram_size;
  logic [31:0]     inst_sram_addr, inst_sram_rdata;
  logic            data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]      data_sram_size;
  logic [3:0]      data_sram_wstrb;
  logic [31:0]     data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [ID_W-1:0] arid, rid;
  logic [31:0]     araddr, rdata, awaddr, wdata;
  logic [2:0]      arsize, awsize;
  logic            arvalid, arready, rvalid, rready;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]      wstrb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_inst[$];
  logic [32:0] sb_data[$];  // {is_write, rdata}

  always #5 clk = ~clk;

  sram_axi_bridge #(.ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_sram_req = 1'b0; inst_sram_size = 2'd2; inst_sram_addr = 32'h0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  // act as the read slave for one AR; returns at the drive point of the idle cycle
  task automatic serve_read(input string tag, input logic [ID_W-1:0] exp_id,
                            input logic [31:0] exp_addr);
    int n = 0;
    while (!arvalid && n < 20) begin
      tick(); settle(); n++;
    end
    check_eq({tag, "_arvalid"}, arvalid, 1'b1);
    check_eq({tag, "_arid"}, arid, exp_id);
    check_eq({tag, "_araddr"}, araddr, exp_addr);
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = exp_id; rdata = mem_val(exp_addr);
    settle();
    tick();
    rvalid = 1'b0;
  endtask

  // act as the write slave for one AW/W pair plus B
  task automatic serve_write(input string tag, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
    int n = 0;
    while (!awvalid && n < 20) begin
      tick(); settle(); n++;
    end
    check_eq({tag, "_awvalid"}, awvalid, 1'b1);
    check_eq({tag, "_awaddr"}, awaddr, exp_addr);
    check_eq({tag, "_wdata"}, wdata, exp_data);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    settle();
    check_eq({tag, "_bready"}, bready, 1'b1);
    tick();
    bvalid = 1'b0;
  endtask

  // retire queued expectations whenever a port reports data_ok
  always @(negedge clk) begin
    if (inst_sram_data_ok) begin
      if (sb_inst.size() == 0) check_eq("inst_data_ok_unexpected", 64'(sb_inst.size()), 64'd1);
      else check_eq("inst_rdata", inst_sram_rdata, sb_inst.pop_front());
    end
    if (data_sram_data_ok) begin
      if (sb_data.size() == 0) check_eq("data_data_ok_unexpected", 64'(sb_data.size()), 64'd1);
      else check_eq("data_resp", {bvalid & bready, (bvalid & bready) ? 32'h0 : data_sram_rdata},
                    sb_data.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    inst_sram_req = 1'b1;
    settle();
    check_eq("rst_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    check_eq("rst_arvalid", arvalid, 1'b0);
    check_eq("rst_awvalid", awvalid, 1'b0);
    check_eq("rst_rready_bready", {rready, bready, wvalid}, 3'b000);
    check_eq("rst_arid_araddr", {arid, araddr}, 36'h0);
    check_eq("rst_awaddr_wdata_wstrb", {awaddr, wdata, wstrb}, 68'h0);
    tick();
    reset = 1'b0; inst_sram_req = 1'b0;

    // inst read with AR latency 1 and R at cycle 4
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2;
    settle();
    check_eq("t1_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b10);
    sb_inst.push_back(32'h0280_0000);
    tick();
    inst_sram_req = 1'b0;
    settle();
    check_eq("t1_ar", {arvalid, arid, arsize}, {1'b1, 4'd0, 3'd2});
    check_eq("t1_araddr", araddr, 32'h1c00_0000);
    tick();
    arready = 1'b1;
    settle();
    check_eq("t1_arvalid_held", arvalid, 1'b1);
    tick();
    arready = 1'b0;
    settle();
    check_eq("t1_rready", {arvalid, rready}, 2'b01);
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0000;
    settle();
    check_eq("t1_data_ok", inst_sram_data_ok, 1'b1);
    tick();
    rvalid = 1'b0;
    settle();
    check_eq("t1_data_ok_once", {inst_sram_data_ok, rready}, 2'b00);

    // tie between inst and data reads
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0040;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0100;
    settle();
    check_eq("t2_first_tie", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b01);
    sb_data.push_back({1'b0, mem_val(32'h0000_0100)});
    tick();
    data_sram_req = 1'b0;
    settle();
    check_eq("t2_inst_waits", inst_sram_addr_ok, 1'b0);
    serve_read("t2a", 4'd1, 32'h0000_0100);
    data_sram_req = 1'b1; data_sram_addr = 32'h0000_0200;
    settle();
`ifdef SRAM_AXI_RR_ARB_EN
    check_eq("t2_second_tie_rr", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b10);
    sb_inst.push_back(mem_val(32'h1c00_0040));
    tick();
    inst_sram_req = 1'b0;
    settle();
    serve_read("t2b", 4'd0, 32'h1c00_0040);
    settle();
    check_eq("t2_data_after", data_sram_addr_ok, 1'b1);
    sb_data.push_back({1'b0, mem_val(32'h0000_0200)});
    tick();
    data_sram_req = 1'b0;
    settle();
    serve_read("t2c", 4'd1, 32'h0000_0200);
`else
    check_eq("t2_second_tie_fixed", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b01);
    sb_data.push_back({1'b0, mem_val(32'h0000_0200)});
    tick();
    data_sram_req = 1'b0;
    settle();
    serve_read("t2b", 4'd1, 32'h0000_0200);
    settle();
    check_eq("t2_inst_after", inst_sram_addr_ok, 1'b1);
    sb_inst.push_back(mem_val(32'h1c00_0040));
    tick();
    inst_sram_req = 1'b0;
    settle();
    serve_read("t2c", 4'd0, 32'h1c00_0040);
`endif

    // write with W immediate and AW delayed
    tick();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0800;
    data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'hF;
    settle();
    check_eq("t3_addr_ok", data_sram_addr_ok, 1'b1);
    sb_data.push_back({1'b1, 32'h0});
    tick();
    data_sram_req = 1'b0; data_sram_wr = 1'b0; wready = 1'b1;
    settle();
    check_eq("t3_valids", {awvalid, wvalid, awsize}, {1'b1, 1'b1, 3'd2});
    check_eq("t3_payload", {awaddr, wdata, wstrb}, {32'h0000_0800, 32'h1234_5678, 4'hF});
    tick();
    wready = 1'b0;
    settle();
    check_eq("t3_w_done", {awvalid, wvalid}, 2'b10);
    tick();
    settle();
    check_eq("t3_aw_held3", awvalid, 1'b1);
    tick();
    awready = 1'b1;
    settle();
    check_eq("t3_aw_held4", {awvalid, bready}, 2'b10);
    tick();
    awready = 1'b0;
    settle();
    check_eq("t3_bready", {awvalid, bready}, 2'b01);
    tick();
    bvalid = 1'b1;
    settle();
    check_eq("t3_data_ok", data_sram_data_ok, 1'b1);
    tick();
    bvalid = 1'b0;
    settle();
    check_eq("t3_idle", {data_sram_data_ok, bready}, 2'b00);

    // data read held off by an outstanding write to the same address
    tick();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_wdata = 32'hCAFE_0001;
    settle();
    check_eq("t4_wr_addr_ok", data_sram_addr_ok, 1'b1);
    sb_data.push_back({1'b1, 32'h0});
    tick();
    data_sram_wr = 1'b0; awready = 1'b1; wready = 1'b1;
    settle();
    check_eq("t4_rd_blocked_send", data_sram_addr_ok, 1'b0);
    tick();
    awready = 1'b0; wready = 1'b0;
    settle();
    check_eq("t4_rd_blocked_b", {data_sram_addr_ok, bready}, 2'b01);
    tick();
    bvalid = 1'b1;
    settle();
    check_eq("t4_rd_blocked_bfire", {data_sram_addr_ok, data_sram_data_ok}, 2'b01);
    tick();
    bvalid = 1'b0;
    settle();
    check_eq("t4_rd_granted", data_sram_addr_ok, 1'b1);
    sb_data.push_back({1'b0, mem_val(32'h0000_0800)});
    tick();
    data_sram_req = 1'b0;
    settle();
    serve_read("t4", 4'd1, 32'h0000_0800);

    // data write held off by an outstanding data read
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0300;
    settle();
    check_eq("t4b_rd_ok", data_sram_addr_ok, 1'b1);
    sb_data.push_back({1'b0, mem_val(32'h0000_0300)});
    tick();
    data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0400; data_sram_wdata = 32'h0BAD_F00D;
    settle();
    check_eq("t4b_wr_blocked", data_sram_addr_ok, 1'b0);
    serve_read("t4b", 4'd1, 32'h0000_0300);
    settle();
    check_eq("t4b_wr_ok", data_sram_addr_ok, 1'b1);
    sb_data.push_back({1'b1, 32'h0});
    tick();
    data_sram_req = 1'b0; data_sram_wr = 1'b0;
    settle();
    serve_write("t4b", 32'h0000_0400, 32'h0BAD_F00D);

    // inst read concurrent with data write, R and B in the same cycle
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0080;
    settle();
    check_eq("t5_inst_ok", inst_sram_addr_ok, 1'b1);
    sb_inst.push_back(mem_val(32'h1c00_0080));
    tick();
    inst_sram_req = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0900;
    data_sram_wdata = 32'hA5A5_1234;
    settle();
    check_eq("t5_wr_ok_during_inst", {data_sram_addr_ok, arvalid}, 2'b11);
    sb_data.push_back({1'b1, 32'h0});
    tick();
    data_sram_req = 1'b0; data_sram_wr = 1'b0; arready = 1'b1; awready = 1'b1; wready = 1'b1;
    settle();
    tick();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    settle();
    check_eq("t5_both_wait", {rready, bready}, 2'b11);
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = mem_val(32'h1c00_0080); bvalid = 1'b1;
    settle();
    check_eq("t5_both_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b11);
    tick();
    rvalid = 1'b0; bvalid = 1'b0;
    settle();
    check_eq("t5_both_clear", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);

    // reset while the read is in RD_R and the write is in flight
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_00c0;
    settle();
    sb_inst.push_back(mem_val(32'h1c00_00c0));
    tick();
    inst_sram_req = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0a00;
    settle();
    check_eq("t6_wr_ok", data_sram_addr_ok, 1'b1);
    tick();
    data_sram_req = 1'b0; data_sram_wr = 1'b0; arready = 1'b1;
    settle();
    tick();
    arready = 1'b0; reset = 1'b1;
    sb_inst.delete();
    sb_data.delete();
    settle();
    check_eq("t6_in_rd_r", rready, 1'b1);
    tick();
    reset = 1'b0;
    settle();
    check_eq("t6_valids_low", {arvalid, rready, awvalid, wvalid, bready}, 5'b00000);
    tick();
    rvalid = 1'b1; rid = 4'd0; bvalid = 1'b1;
    settle();
    check_eq("t6_no_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);
    tick();
    rvalid = 1'b0; bvalid = 1'b0;
    repeat (2) tick();

    check_eq("sb_inst_drained", 64'(sb_inst.size()), 64'd0);
    check_eq("sb_data_drained", 64'(sb_data.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Shares one AXI3 master port between the core's inst sram-like port (read-only) and data sram-like port (read/write).
- Sits between mycpu_top and the SoC AXI interconnect.
- Arbitrates the single read channel, sequences AR/R and AW/W/B handshakes, and returns data_ok in request order per port.
- At most one outstanding read and one outstanding write at any time.

Parameters:
- ID_W, 4, AXI id width; inst reads use id 0, data reads use id 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_sram_req / data_sram_req  in  1  request valid
- data_sram_wr  in  1  1 = write
- inst_sram_size / data_sram_size  in  2  bytes = 2^size
- data_sram_wstrb  in  4  byte strobes
- inst_sram_addr / data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data
- inst_sram_addr_ok / data_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok / data_sram_data_ok  out  1  response this cycle
- inst_sram_rdata / data_sram_rdata  out  32  read data, valid with data_ok
- arid  out  ID_W;  araddr  out  32;  arsize  out  3;  arvalid  out  1;  arready  in  1
- rid  in  ID_W;  rdata  in  32;  rvalid  in  1;  rready  out  1
- awaddr  out  32;  awsize  out  3;  awvalid  out  1;  awready  in  1
- wdata  out  32;  wstrb  out  4;  wvalid  out  1;  wready  in  1
- bvalid  in  1;  bready  out  1
- Constant AXI sideband fields are tied in mycpu_top, not here: len=0, burst=INCR, lock/cache/prot=0, wid=1, wlast=1.

Behaviour:
- Clocking and reset
  - All state on clk posedge; one clock domain.
  - On reset: both FSMs idle; arvalid, awvalid, wvalid, rready, bready, all addr_ok/data_ok = 0; arid/araddr/awaddr/wdata/wstrb registers = 0.
- Read FSM: RD_IDLE -> RD_AR -> RD_R -> RD_IDLE
  - In RD_IDLE the grant goes to the data port if data_sram_req & !data_sram_wr and the write FSM is idle. Otherwise it goes to inst if inst_sram_req.
  - Grant asserts that port's addr_ok combinationally in the same cycle.
  - Next cycle: RD_AR with arvalid=1, arid = 0 (inst) or 1 (data), araddr, arsize = {1'b0,size}.
  - arvalid holds until arready; then RD_R with rready=1.
  - On rvalid: the port selected by rid gets data_ok=1 for exactly one cycle, with rdata passed through combinationally. FSM returns to RD_IDLE.
  - rresp is ignored.
- Write FSM: WR_IDLE -> WR_SEND -> WR_B -> WR_IDLE
  - In WR_IDLE, data_sram_req & data_sram_wr is accepted (addr_ok=1) only if no data read is in RD_AR/RD_R.
  - On accept, capture awaddr, awsize, wdata, wstrb; next cycle awvalid=wvalid=1.
  - awvalid and wvalid each deassert independently on their own handshake. Move to WR_B when both are done, including the same-cycle case.
  - bready=1 in WR_B. The B handshake gives data_sram_data_ok=1; then WR_IDLE.
- Ordering
  - A data read is blocked while a write is outstanding, and a data write is blocked while a data read is outstanding. This keeps data port responses in order and removes read-after-write hazards.
  - Inst reads and data writes proceed concurrently.
- Simultaneous events
  - A data read and a data write can never both be outstanding, so data_sram_data_ok is never double-driven.
  - An inst R response and a B response in the same cycle both complete; each port gets its data_ok.
  - The data port may present req while addr_ok is low; the bridge must not latch the request until addr_ok=1.
- Latency: minimum read = addr_ok cycle + 1 (AR) + slave latency. data_ok arrives in the rvalid cycle.
- Reset during any state: next cycle all valids are low and no data_ok is issued. The outstanding AXI transfer is abandoned; the slave is reset with the core.

Optional Feature:
- Macro SRAM_AXI_RR_ARB_EN.
- Defined: read arbitration is round-robin. A 1-bit last_grant register (reset = inst) gives priority to the port not served last when both request.
- Undefined: fixed data-over-inst priority, as described above.

Decomposition:
- Shared package (mycpu_head.vh): read FSM state encodings, write FSM state encodings, ID_INST=0, ID_DATA=1.
- Natural sub-module: axi_wr_channel (write FSM plus AW/W/B registers). Read FSM and arbiter stay in the top module.

Test Plan:
- Inst read 0x1c000000: addr_ok in cycle 0; cycle 1 arvalid=1, arid=0, arsize=2; arready at cycle 2; rvalid with rid=0, rdata=0x02800000 at cycle 4 -> inst_sram_data_ok=1 in cycle 4 only, rdata=0x02800000.
- Inst and data read requested in the same cycle -> data granted (arid=1). Inst addr_ok stays 0 until RD_IDLE, then inst is granted. With SRAM_AXI_RR_ARB_EN defined and last_grant at its reset value (inst), data wins the first tie; after that data read completes, an inst-vs-data tie goes to inst.
- Data write to 0x800, wstrb=0xF, wdata=0x12345678; wready immediate, awready delayed 3 cycles -> wvalid drops after 1 cycle; awvalid held 4 cycles; bvalid -> data_sram_data_ok one cycle.
- Data write then data read to 0x800 -> read addr_ok=0 until the B handshake; the read is granted in the first cycle after WR_IDLE.
- Inst read outstanding while a data write is issued; R (rid=0) and B in the same cycle -> inst_sram_data_ok and data_sram_data_ok both 1 in that cycle.
- reset asserted in RD_R -> next cycle arvalid/rready/awvalid/wvalid/bready=0; a later rvalid produces no data_ok.
